// File: rtl/pipe_arith_unit_if.sv
// pipe_arith_unit_if: operand/result valid-ready bundle for pipe_arith_unit
interface pipe_arith_unit_if #(parameter int W = 8) ();
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    logic         carry;
    logic         ovf;
    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, y, carry, ovf
    );
    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, y, carry, ovf
    );
endinterface

// File: rtl/pipe_arith_unit.sv
// pipe_arith_unit: pipelined add/sub with carry/ovf and full backpressure; saturation via PIPE_ARITH_SAT_EN
module pipe_arith_unit #(
    parameter int W      = 8,
    parameter int STAGES = 2
) (
    input logic              clk,
    input logic              rst_n,
    pipe_arith_unit_if.slave bus
);
    logic                     sub;
    logic                     c;
    logic                     sovf;
    logic                     rovf;
    logic [W:0]               sum;
    logic [W:0]               dif;
    logic [W:0]               r;
    logic [W-1:0]             res;
    logic [STAGES:0]          adv;
    logic [STAGES-1:0]        vld_d, vld_q;
    logic [STAGES-1:0][W+1:0] pl_d, pl_q;

    // result and flags for the operand pair presented this cycle
    always_comb begin
        sub  = bus.op[0];
        sum  = {1'b0, bus.a} + {1'b0, bus.b};
        dif  = {1'b0, bus.a} - {1'b0, bus.b};
        r    = sub ? dif : sum;
        c    = r[W];
        sovf = (bus.a[W-1] ^ bus.b[W-1] ^ ~sub) & (r[W-1] ^ bus.a[W-1]);
`ifdef PIPE_ARITH_SAT_EN
        res  = (bus.op[1] && c) ? (sub ? '0 : '1) : r[W-1:0];
        rovf = bus.op[1] ? c : sovf;
`else
        res  = r[W-1:0];
        rovf = sovf;
`endif
    end

    // stall chain: a stage moves when empty or its successor moves; payload only loads with valid data
    always_comb begin
        adv[STAGES] = bus.out_ready;
        for (int k = STAGES - 1; k >= 0; k--) adv[k] = !vld_q[k] || adv[k+1];
        vld_d = vld_q;
        pl_d  = pl_q;
        if (adv[0]) vld_d[0] = bus.in_valid;
        if (adv[0] && bus.in_valid) pl_d[0] = {rovf, c, res};
        for (int k = 1; k < STAGES; k++) begin
            if (adv[k]) vld_d[k] = vld_q[k-1];
            if (adv[k] && vld_q[k-1]) pl_d[k] = pl_q[k-1];
        end
    end

    // pipeline registers, cleared asynchronously so in-flight work is discarded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            pl_q  <= '0;
        end else begin
            vld_q <= vld_d;
            pl_q  <= pl_d;
        end
    end

    assign bus.in_ready                   = adv[0];
    assign bus.out_valid                  = vld_q[STAGES-1];
    assign {bus.ovf, bus.carry, bus.y}    = pl_q[STAGES-1];
endmodule

// File: tb/tb_pipe_arith_unit.sv
// tb_pipe_arith_unit: scoreboard bench for pipe_arith_unit (STAGES=2 main instance, STAGES=1 regression instance)
module tb_pipe_arith_unit;
    localparam int W = 8;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   n_acc = 0;
    int   n_out = 0;
    logic [W+1:0] sb[$];
    logic [W+1:0] e;

    always #5 clk = ~clk;

    pipe_arith_unit_if #(.W(W)) bus ();
    pipe_arith_unit_if #(.W(W)) bus1 ();

    pipe_arith_unit #(.W(W), .STAGES(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    pipe_arith_unit #(.W(W), .STAGES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [W+1:0] model(input logic [1:0] o, input int ua, input int ub);
        int m = 1 << W;
        int h = m / 2;
        int sa, sb_, s, ss, yy;
        logic cy, ov;
        sa  = ua >= h ? ua - m : ua;
        sb_ = ub >= h ? ub - m : ub;
        if (o[0]) begin
            s = ua - ub; cy = ua < ub; ss = sa - sb_;
        end else begin
            s = ua + ub; cy = s >= m; ss = sa + sb_;
        end
        yy = ((s % m) + m) % m;
        ov = ss >= h || ss < -h;
`ifdef PIPE_ARITH_SAT_EN
        if (o[1]) begin
            ov = cy;
            if (cy) yy = o[0] ? 0 : m - 1;
        end
`endif
        return {ov, cy, yy[W-1:0]};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) sb.delete();
        else begin
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back(model(bus.op, int'(bus.a), int'(bus.b)));
                n_acc++;
            end
            if (bus.out_valid && bus.out_ready) begin
                n_out++;
                if (sb.size() == 0) check("unexpected_out", 1, 0);
                else begin
                    e = sb.pop_front();
                    check("y", bus.y, e[W-1:0]);
                    check("carry", bus.carry, e[W]);
                    check("ovf", bus.ovf, e[W+1]);
                end
            end
        end
    end

    task automatic send(input logic [1:0] o, input int x, input int yv);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.op       = o;
        bus.a        = x[W-1:0];
        bus.b        = yv[W-1:0];
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) check("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || bus.out_valid) && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drained", sb.size(), 0);
    endtask

    task automatic lat_check(input logic [1:0] o, input int x, input int yv);
        send(o, x, yv);
        @(negedge clk);
        check("lat_early", bus.out_valid, 0);
        @(negedge clk);
        check("lat_on", bus.out_valid, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] yh;
        logic         ch, oh;
        int           base, obase;
        bus.in_valid   = 1'b0; bus.op  = '0; bus.a  = '0; bus.b  = '0; bus.out_ready  = 1'b1;
        bus1.in_valid  = 1'b0; bus1.op = '0; bus1.a = '0; bus1.b = '0; bus1.out_ready = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_y", bus.y, 0);
        check("rst_carry", bus.carry, 0);
        check("rst_ovf", bus.ovf, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_in_ready", bus.in_ready, 1);

        lat_check(2'b00, 200, 100);
        send(2'b00, 100, 100);
        send(2'b01, 5, 10);
        send(2'b01, 128, 1);
        send(2'b10, 200, 100);
        send(2'b11, 5, 10);
        send(2'b10, 3, 4);
        drain();

        bus.out_ready = 1'b0;
        base  = n_acc;
        obase = n_out;
        fork
            for (int i = 0; i < 6; i++) send(i[1:0], 30 * i + 170, 11 * i + 3);
            begin
                repeat (3) @(negedge clk);
                yh = bus.y; ch = bus.carry; oh = bus.ovf;
                repeat (2) @(negedge clk);
                check("bp_accepted", n_acc - base, 2);
                check("bp_in_ready", bus.in_ready, 0);
                check("bp_out_valid", bus.out_valid, 1);
                check("bp_hold_y", bus.y, yh);
                check("bp_hold_carry", bus.carry, ch);
                check("bp_hold_ovf", bus.ovf, oh);
                @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        drain();
        check("bp_count", n_out - obase, 6);

        send(2'b00, 1, 2);
        send(2'b00, 3, 4);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_y", bus.y, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        obase = n_out;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_quiet", bus.out_valid, 0);
        end
        check("post_rst_none", n_out - obase, 0);
        @(posedge clk);
        #1;
        lat_check(2'b01, 5, 10);
        drain();

        bus1.in_valid = 1'b1; bus1.op = 2'b00; bus1.a = 8'd7; bus1.b = 8'd9;
        @(negedge clk);
        check("s1_ready", bus1.in_ready, 1);
        check("s1_idle", bus1.out_valid, 0);
        @(posedge clk);
        #1 bus1.in_valid = 1'b0;
        check("s1_valid", bus1.out_valid, 1);
        check("s1_y", bus1.y, 16);
        check("s1_carry", bus1.carry, 0);
        @(posedge clk);
        #1;
        check("s1_drop", bus1.out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
